// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for serial_subtractor
// SERIAL_SUB_OVF_EN adds the signed overflow flag ovf to the bus
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
   modport master (output start, a, b, input busy, done, diff, bout, ovf);
   modport slave (input start, a, b, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, bout);
   modport slave (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor step per clock
// SERIAL_SUB_OVF_EN enables the signed overflow output ovf
module serial_subtractor #(parameter int WIDTH = 8) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, nxt;
   logic [WIDTH-1:0] sa, sb, sd, diff;
   logic [CW-1:0]    cnt;
   logic             borrow, bout, d, bnext, accept, last;
   assign d      = sa[0] ^ sb[0] ^ borrow;
   assign bnext  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
   assign accept = bus.start && state != RUN;
   assign last   = state == RUN && cnt == LAST;
   assign bus.diff = diff;
   assign bus.bout = bout;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
   always_comb begin
      bus.busy = state == RUN;
      bus.done = state == DONE;
   end
   // diff/bout are only loaded on the final step so partial results never show
   always_ff @(posedge clk)
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         sd     <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (accept) begin
         sa     <= bus.a;
         sb     <= bus.b;
         borrow <= 1'b0;
         cnt    <= '0;
      end else if (state == RUN) begin
         sa     <= sa >> 1;
         sb     <= sb >> 1;
         sd     <= {d, sd[WIDTH-1:1]};
         borrow <= bnext;
         cnt    <= last ? cnt : cnt + 1'b1;
         if (last) begin
            diff <= {d, sd[WIDTH-1:1]};
            bout <= bnext;
         end
      end
`ifdef SERIAL_SUB_OVF_EN
   logic am, bm, ovf;
   assign bus.ovf = ovf;
   // on the last step d is the result MSB
   always_ff @(posedge clk)
      if (rst) begin
         am  <= 1'b0;
         bm  <= 1'b0;
         ovf <= 1'b0;
      end else if (accept) begin
         am <= bus.a[WIDTH-1];
         bm <= bus.b[WIDTH-1];
      end else if (last) ovf <= (am != bm) && (d != am);
`endif
endmodule
